link_ddr_rx_channel: RTL

//  Receive side of one DDR link channel; sits directly downstream of the DDR upstream

---
 rtl/link_ddr_rx_channel_if.sv | 26 ++
 rtl/link_ddr_rx_channel.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/link_ddr_rx_channel_if.sv
// rtl/link_ddr_rx_channel_if.sv - link-side and core-side signal bundle for one DDR receive channel
interface link_ddr_rx_channel_if #(
  parameter int CHANNEL_WIDTH = 8
);
  logic                       io_valid_pos_i;
  logic [CHANNEL_WIDTH-1:0]   io_data_pos_i;
  logic                       io_valid_neg_i;
  logic [CHANNEL_WIDTH-1:0]   io_data_neg_i;
  logic                       core_valid_o;
  logic [2*CHANNEL_WIDTH-1:0] core_data_o;
  logic                       core_yumi_i;
  logic                       token_o;
  logic                       error_o;

  // Environment side: drives the link phases and the core consume strobe.
  modport master (
    output io_valid_pos_i, io_data_pos_i, io_valid_neg_i, io_data_neg_i, core_yumi_i,
    input  core_valid_o, core_data_o, token_o, error_o
  );

  // Receive channel side.
  modport slave (
    input  io_valid_pos_i, io_data_pos_i, io_valid_neg_i, io_data_neg_i, core_yumi_i,
    output core_valid_o, core_data_o, token_o, error_o
  );
endinterface

// File: rtl/link_ddr_rx_channel.sv
// rtl/link_ddr_rx_channel.sv - DDR link receive channel: phase pairing, credit FIFO, token return; optional error mode via LINK_DDR_RX_ERROR_EN
module link_ddr_rx_channel #(
  parameter int CHANNEL_WIDTH = 8,
  parameter int FIFO_DEPTH    = 64,
  parameter int TOKEN_RATIO   = 8,
  parameter int INIT_CYCLES   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  link_ddr_rx_channel_if.slave bus
);
  localparam int WW = 2 * CHANNEL_WIDTH;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TW = (TOKEN_RATIO > 1) ? $clog2(TOKEN_RATIO) : 1;
  localparam int IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

  localparam logic [1:0] ST_INIT   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
`ifdef LINK_DDR_RX_ERROR_EN
  localparam logic [1:0] ST_ERROR  = 2'd2;
`endif

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] init_cnt_q, init_cnt_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic [TW-1:0] pop_cnt_q, pop_cnt_d;
  logic          token_q, token_d;
  logic [WW-1:0] mem_q [FIFO_DEPTH];

  logic not_empty;
  logic full;
  logic push_req;
  logic push;
  logic pop;
  logic pop_wrap;

  assign not_empty = (count_q != '0);
  assign full      = (count_q == (AW+1)'(FIFO_DEPTH));
  assign pop       = bus.core_yumi_i & not_empty;
  assign push_req  = (state_q == ST_ACTIVE) & bus.io_valid_pos_i & bus.io_valid_neg_i;
  // A full FIFO still takes a word when the head leaves in the same cycle.
  assign push      = push_req & (~full | pop);
  assign pop_wrap  = pop & (pop_cnt_q == TW'(TOKEN_RATIO - 1));

`ifdef LINK_DDR_RX_ERROR_EN
  logic link_err;
  logic error_q, error_d;
  // Half a word on the link or a word with no room both mean the credit loop is broken.
  assign link_err = (state_q == ST_ACTIVE) &
                    ((bus.io_valid_pos_i ^ bus.io_valid_neg_i) | (push_req & ~push));
  assign error_d  = error_q | link_err;
`endif

  // Channel state: hold off the link during init, then accept pairs.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      ST_INIT: begin
        if (init_cnt_q == IW'(INIT_CYCLES - 1)) begin
          state_d = ST_ACTIVE;
        end else begin
          init_cnt_d = init_cnt_q + 1'b1;
        end
      end
      ST_ACTIVE: begin
`ifdef LINK_DDR_RX_ERROR_EN
        if (link_err) begin
          state_d = ST_ERROR;
        end
`endif
      end
      default: ;
    endcase
  end

  // FIFO pointer/occupancy and credit-token next state.
  always_comb begin
    wptr_d    = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d    = pop  ? rptr_q + 1'b1 : rptr_q;
    count_d   = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
    pop_cnt_d = pop_cnt_q;
    if (pop) begin
      pop_cnt_d = pop_wrap ? '0 : pop_cnt_q + 1'b1;
    end
    token_d   = token_q ^ pop_wrap;
  end

  // Control registers; buffered words are abandoned on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      pop_cnt_q  <= '0;
      token_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      pop_cnt_q  <= pop_cnt_d;
      token_q    <= token_d;
    end
  end

  // Word storage: the neg phase forms the high byte.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= {bus.io_data_neg_i, bus.io_data_pos_i};
    end
  end

`ifdef LINK_DDR_RX_ERROR_EN
  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      error_q <= 1'b0;
    end else begin
      error_q <= error_d;
    end
  end
  assign bus.error_o = error_q;
`else
  assign bus.error_o = 1'b0;
`endif

  assign bus.core_valid_o = not_empty;
  assign bus.core_data_o  = not_empty ? mem_q[rptr_q] : '0;
  assign bus.token_o      = token_q;
endmodule
